// File: rtl/delta_pkg.sv
// delta_pkg: width helpers, saturation constants and FSM state type shared
// by the backprop delta serialiser and its per-channel lane calculator.
package delta_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int SATCNT_W = 16;

  // Accum1 width: enough integer headroom for an NP-way sum plus WF fraction bits.
  function automatic int wa1(input int np, input int wf);
    return $clog2(np) + 1 + wf;
  endfunction

  // Accum2 width: error fan-in sum in hidden mode, same as Accum1 in output mode.
  function automatic int wa2(input int hidden, input int np, input int nn, input int wf);
    return (hidden != 0) ? ($clog2(nn) + wf) : wa1(np, wf);
  endfunction

  // Activation upper bound used by the derivative gate.
  function automatic int one_c(input int wf);
    return (1 << (wf - 1)) - 1;
  endfunction

  function automatic int max_c(input int wf);
    return (1 << (wf - 1)) - 1;
  endfunction

  function automatic int min_c(input int wf);
    return -(1 << (wf - 1));
  endfunction

endpackage

// File: rtl/delta_lane_calc.sv
// delta_lane_calc: one channel of the delta computation. Hidden mode passes
// the error sum only while the activation sits inside [0, ONE]; output mode
// takes the difference one bit wider than the inputs so it never wraps.
// Result is clipped to the signed WF-bit range; sat_o flags a clip.
module delta_lane_calc
  import delta_pkg::*;
#(
  parameter int HIDDEN = 1,
  parameter int WA1    = 8,
  parameter int WA2    = 7,
  parameter int WF     = 4
) (
  input  logic signed [WA1-1:0] a1_i,
  input  logic signed [WA2-1:0] a2_i,
  output logic        [WF-1:0]  d_o,
  output logic                  sat_o
);

  localparam int TW = ((WA1 > WA2) ? WA1 : WA2) + 1;
  localparam logic signed [TW-1:0] MAX_T = TW'(max_c(WF));
  localparam logic signed [TW-1:0] MIN_T = TW'(min_c(WF));

  logic signed [TW-1:0] t;

  if (HIDDEN != 0) begin : g_gate
    localparam logic signed [WA1-1:0] ONE_A = WA1'(one_c(WF));
    // Derivative gate: zero outside the linear activation region.
    always_comb t = ((a1_i > ONE_A) || a1_i[WA1-1]) ? '0 : TW'(a2_i);
  end else begin : g_diff
    // Output error: difference at full width.
    always_comb t = TW'(a1_i) - TW'(a2_i);
  end

  // Clip to the WF-bit signed range.
  always_comb begin
    sat_o = 1'b0;
    d_o   = t[WF-1:0];
    if (t > MAX_T) begin
      d_o   = MAX_T[WF-1:0];
      sat_o = 1'b1;
    end else if (t < MIN_T) begin
      d_o   = MIN_T[WF-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/delta_serial_bcast.sv
// delta_serial_bcast: joins the Accum1/Accum2 vector streams, computes NC
// saturated deltas, then serialises them NL lanes per beat to two
// independently back-pressured consumers. A port that has taken the current
// beat drops valid until the other port has also taken it.
// Optional: define DELTA_SATCNT_EN to add oSatCount, a saturating 16-bit
// count of clipped channels over all accepted vectors.
//
// state | meaning
// IDLE  | no vector held, waiting for both inputs valid
// SEND  | presenting beat beat_q of the held delta vector
module delta_serial_bcast
  import delta_pkg::*;
#(
  parameter int HIDDEN = 1,
  parameter int NP     = 5,
  parameter int NC     = 6,
  parameter int NN     = 7,
  parameter int WF     = 4,
  parameter int NL     = 2,
  localparam int WA1   = wa1(NP, WF),
  localparam int WA2   = wa2(HIDDEN, NP, NN, WF),
  localparam int LW    = NL * WF
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iValid_AS_Accum1,
  output logic               oReady_AS_Accum1,
  input  logic [NC*WA1-1:0]  iData_AS_Accum1,
  input  logic               iValid_AS_Accum2,
  output logic               oReady_AS_Accum2,
  input  logic [NC*WA2-1:0]  iData_AS_Accum2,
  output logic               oValid_BM_Delta0,
  input  logic               iReady_BM_Delta0,
  output logic [LW-1:0]      oData_BM_Delta0,
  output logic               oLast_BM_Delta0,
  output logic               oValid_BM_Delta1,
  input  logic               iReady_BM_Delta1,
  output logic [LW-1:0]      oData_BM_Delta1,
  output logic               oLast_BM_Delta1
`ifdef DELTA_SATCNT_EN
  ,
  output logic [SATCNT_W-1:0] oSatCount
`endif
);

  localparam int NB = NC / NL;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  if ((NC % NL) != 0) begin : g_bad_nl
    $error("delta_serial_bcast: NC must be a multiple of NL");
  end

  logic [NC*WF-1:0] calc_w;
  logic [NC-1:0]    sat_w;

  for (genvar c = 0; c < NC; c++) begin : g_lane
    delta_lane_calc #(
      .HIDDEN (HIDDEN),
      .WA1    (WA1),
      .WA2    (WA2),
      .WF     (WF)
    ) u_calc (
      .a1_i  (iData_AS_Accum1[c*WA1 +: WA1]),
      .a2_i  (iData_AS_Accum2[c*WA2 +: WA2]),
      .d_o   (calc_w[c*WF +: WF]),
      .sat_o (sat_w[c])
    );
  end

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             taken0_q, taken0_d, taken1_q, taken1_d;
  logic [NC*WF-1:0] delta_q, delta_d;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic             last_q, last_d;
  logic [LW-1:0]    data_q, data_d;

  logic done0, done1, complete, beat_last, slot_free, acc;

  // Handshake bookkeeping: which ports have the beat, and whether a new vector can enter.
  always_comb begin
    done0     = taken0_q | (valid0_q & iReady_BM_Delta0);
    done1     = taken1_q | (valid1_q & iReady_BM_Delta1);
    complete  = (state_q == SEND) & done0 & done1;
    beat_last = (beat_q == BW'(NB - 1));
    slot_free = (state_q == IDLE) | (complete & beat_last);
    acc       = iValid_AS_Accum1 & iValid_AS_Accum2 & slot_free;
  end

  assign oReady_AS_Accum1 = iValid_AS_Accum2 & slot_free;
  assign oReady_AS_Accum2 = iValid_AS_Accum1 & slot_free;

  // Next-state for the sequencer and the output registers derived from it.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    taken0_d = taken0_q;
    taken1_d = taken1_q;
    delta_d  = delta_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = SEND;
          beat_d  = '0;
          delta_d = calc_w;
        end
      end
      SEND: begin
        if (complete) begin
          taken0_d = 1'b0;
          taken1_d = 1'b0;
          if (beat_last) begin
            beat_d = '0;
            if (acc) delta_d = calc_w;
            else     state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          taken0_d = done0;
          taken1_d = done1;
        end
      end
      default: state_d = IDLE;
    endcase

    data_d = '0;
    if (state_d == SEND) begin
      for (int b = 0; b < NB; b++) begin
        if (beat_d == BW'(b)) data_d = delta_d[b*LW +: LW];
      end
    end
    valid0_d = (state_d == SEND) & ~taken0_d;
    valid1_d = (state_d == SEND) & ~taken1_d;
    last_d   = (state_d == SEND) & (beat_d == BW'(NB - 1));
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      taken0_q <= 1'b0;
      taken1_q <= 1'b0;
      delta_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      taken0_q <= taken0_d;
      taken1_q <= taken1_d;
      delta_q  <= delta_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      last_q   <= last_d;
      data_q   <= data_d;
    end
  end

  assign oValid_BM_Delta0 = valid0_q;
  assign oValid_BM_Delta1 = valid1_q;
  assign oData_BM_Delta0  = data_q;
  assign oData_BM_Delta1  = data_q;
  assign oLast_BM_Delta0  = last_q;
  assign oLast_BM_Delta1  = last_q;

`ifdef DELTA_SATCNT_EN
  logic [SATCNT_W-1:0] satcnt_q, satcnt_d;
  logic [SATCNT_W:0]   satsum;

  // Add this vector's clipped-channel count, sticking at all-ones.
  always_comb begin
    satsum = {1'b0, satcnt_q};
    for (int c = 0; c < NC; c++) satsum = satsum + (SATCNT_W+1)'(sat_w[c]);
    satcnt_d = satcnt_q;
    if (acc) satcnt_d = satsum[SATCNT_W] ? '1 : satsum[SATCNT_W-1:0];
  end

  // Saturation counter register.
  always_ff @(posedge iCLK) begin
    if (!iRST) satcnt_q <= '0;
    else       satcnt_q <= satcnt_d;
  end

  assign oSatCount = satcnt_q;
`else
  logic unused_sat;
  assign unused_sat = ^sat_w;
`endif

endmodule

// File: tb/tb_delta_serial_bcast.sv
// tb_delta_serial_bcast: directed vectors against a hidden-mode and an
// output-mode instance, expected beats worked out by hand (WF=4, NL=2).
module tb_delta_serial_bcast;

  localparam int NC   = 6;
  localparam int WA1  = 8;
  localparam int WA2H = 7;
  localparam int WA2O = 8;
  localparam int LW   = 8;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;
  logic iRST;

  logic h_v1, h_v2, h_r1, h_r2, h_ov0, h_ir0, h_ol0, h_ov1, h_ir1, h_ol1;
  logic [NC*WA1-1:0]  h_d1;
  logic [NC*WA2H-1:0] h_d2;
  logic [LW-1:0]      h_od0, h_od1;

  logic o_v1, o_v2, o_r1, o_r2, o_ov0, o_ir0, o_ol0, o_ov1, o_ir1, o_ol1;
  logic [NC*WA1-1:0]  o_d1;
  logic [NC*WA2O-1:0] o_d2;
  logic [LW-1:0]      o_od0, o_od1;

`ifdef DELTA_SATCNT_EN
  logic [15:0] h_sc, o_sc;
`endif

  delta_serial_bcast #(.HIDDEN(1), .NP(5), .NC(6), .NN(7), .WF(4), .NL(2)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AS_Accum1(h_v1), .oReady_AS_Accum1(h_r1), .iData_AS_Accum1(h_d1),
    .iValid_AS_Accum2(h_v2), .oReady_AS_Accum2(h_r2), .iData_AS_Accum2(h_d2),
    .oValid_BM_Delta0(h_ov0), .iReady_BM_Delta0(h_ir0), .oData_BM_Delta0(h_od0), .oLast_BM_Delta0(h_ol0),
    .oValid_BM_Delta1(h_ov1), .iReady_BM_Delta1(h_ir1), .oData_BM_Delta1(h_od1), .oLast_BM_Delta1(h_ol1)
`ifdef DELTA_SATCNT_EN
    , .oSatCount(h_sc)
`endif
  );

  delta_serial_bcast #(.HIDDEN(0), .NP(5), .NC(6), .NN(7), .WF(4), .NL(2)) dut_o (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AS_Accum1(o_v1), .oReady_AS_Accum1(o_r1), .iData_AS_Accum1(o_d1),
    .iValid_AS_Accum2(o_v2), .oReady_AS_Accum2(o_r2), .iData_AS_Accum2(o_d2),
    .oValid_BM_Delta0(o_ov0), .iReady_BM_Delta0(o_ir0), .oData_BM_Delta0(o_od0), .oLast_BM_Delta0(o_ol0),
    .oValid_BM_Delta1(o_ov1), .iReady_BM_Delta1(o_ir1), .oData_BM_Delta1(o_od1), .oLast_BM_Delta1(o_ol1)
`ifdef DELTA_SATCNT_EN
    , .oSatCount(o_sc)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_h(input int c, input int a1, input int a2);
    h_d1[c*WA1 +: WA1]   = WA1'(a1);
    h_d2[c*WA2H +: WA2H] = WA2H'(a2);
  endtask

  task automatic set_o(input int c, input int a1, input int a2);
    o_d1[c*WA1 +: WA1]   = WA1'(a1);
    o_d2[c*WA2O +: WA2O] = WA2O'(a2);
  endtask

  // Hidden vector A: beats 05, 70, D8
  task automatic load_hA();
    set_h(0, 3, 5);  set_h(1, 9, 5);  set_h(2, -1, 5);
    set_h(3, 2, 20); set_h(4, 2, -12); set_h(5, 7, -3);
  endtask

  // Hidden vector B: beats 78, 80, 07
  task automatic load_hB();
    set_h(0, 0, -8); set_h(1, 7, 7);  set_h(2, 8, 3);
    set_h(3, 5, -9); set_h(4, 1, 63); set_h(5, -128, 1);
  endtask

  task automatic expect_beat(input string tag, input bit sel, input logic [7:0] d, input bit l);
    if (!sel) begin
      check_eq({tag, ".v0"}, h_ov0, 1);
      check_eq({tag, ".v1"}, h_ov1, 1);
      check_eq({tag, ".d0"}, h_od0, d);
      check_eq({tag, ".d1"}, h_od1, d);
      check_eq({tag, ".l0"}, h_ol0, l);
      check_eq({tag, ".l1"}, h_ol1, l);
    end else begin
      check_eq({tag, ".v0"}, o_ov0, 1);
      check_eq({tag, ".v1"}, o_ov1, 1);
      check_eq({tag, ".d0"}, o_od0, d);
      check_eq({tag, ".d1"}, o_od1, d);
      check_eq({tag, ".l0"}, o_ol0, l);
      check_eq({tag, ".l1"}, o_ol1, l);
    end
  endtask

  task automatic expect_idle(input string tag, input bit sel);
    if (!sel) begin
      check_eq({tag, ".v0"}, h_ov0, 0);
      check_eq({tag, ".v1"}, h_ov1, 0);
      check_eq({tag, ".l0"}, h_ol0, 0);
    end else begin
      check_eq({tag, ".v0"}, o_ov0, 0);
      check_eq({tag, ".v1"}, o_ov1, 0);
      check_eq({tag, ".l0"}, o_ol0, 0);
    end
  endtask

  initial begin
    iRST = 1'b0;
    h_v1 = 0; h_v2 = 0; h_ir0 = 1; h_ir1 = 1; h_d1 = '0; h_d2 = '0;
    o_v1 = 0; o_v2 = 0; o_ir0 = 1; o_ir1 = 1; o_d1 = '0; o_d2 = '0;
    repeat (3) step();

    // reset state
    expect_idle("rst_h", 0);
    expect_idle("rst_o", 1);
    check_eq("rst_data", h_od0, 0);
    check_eq("rst_rdy1", h_r1, 0);
    iRST = 1'b1;
    step();

    // hidden mode, both ports ready
    load_hA();
    h_v1 = 1; h_v2 = 1;
    #1;
    check_eq("hA.rdy1", h_r1, 1);
    check_eq("hA.rdy2", h_r2, 1);
    step();
    h_v1 = 0; h_v2 = 0;
    expect_beat("hA.b0", 0, 8'h05, 0);
    step(); expect_beat("hA.b1", 0, 8'h70, 0);
    step(); expect_beat("hA.b2", 0, 8'hD8, 1);
    step(); expect_idle("hA.end", 0);
`ifdef DELTA_SATCNT_EN
    check_eq("hA.satcnt", h_sc, 2);
`endif

    // port1 stalled three cycles, port0 always ready
    load_hA();
    h_v1 = 1; h_v2 = 1; h_ir1 = 0;
    step();
    h_v1 = 0; h_v2 = 0;
    expect_beat("st.b0", 0, 8'h05, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("st.v0_low", h_ov0, 0);
      check_eq("st.v1_high", h_ov1, 1);
      check_eq("st.hold", h_od1, 8'h05);
    end
    h_ir1 = 1;
    step(); expect_beat("st.b1", 0, 8'h70, 0);
    step(); expect_beat("st.b2", 0, 8'hD8, 1);
    step(); expect_idle("st.end", 0);

    // output mode, Accum2 arrives four cycles after Accum1
    set_o(0, 2, -9); set_o(1, -6, 5); set_o(2, 4, 1);
    set_o(3, 0, 0);  set_o(4, -3, -1); set_o(5, 100, -100);
    o_v1 = 1; o_v2 = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("join.rdy1_low", o_r1, 0);
      check_eq("join.no_out", o_ov0, 0);
      step();
    end
    o_v2 = 1;
    #1;
    check_eq("join.rdy1", o_r1, 1);
    check_eq("join.rdy2", o_r2, 1);
    step();
    o_v1 = 0; o_v2 = 0;
    expect_beat("out.b0", 1, 8'h87, 0);
    step(); expect_beat("out.b1", 1, 8'h03, 0);
    step(); expect_beat("out.b2", 1, 8'h7E, 1);
    step(); expect_idle("out.end", 1);

    // back-to-back vectors, no bubble at the boundary
    load_hA();
    h_v1 = 1; h_v2 = 1;
    step();
    load_hB();
    expect_beat("bb.A0", 0, 8'h05, 0);
    #1;
    check_eq("bb.rdy_busy", h_r1, 0);
    step(); expect_beat("bb.A1", 0, 8'h70, 0);
    step(); expect_beat("bb.A2", 0, 8'hD8, 1);
    #1;
    check_eq("bb.rdy_free", h_r1, 1);
    step();
    h_v1 = 0; h_v2 = 0;
    expect_beat("bb.B0", 0, 8'h78, 0);
    step(); expect_beat("bb.B1", 0, 8'h80, 0);
    step(); expect_beat("bb.B2", 0, 8'h07, 1);
    step(); expect_idle("bb.end", 0);

    // reset during beat 1
    load_hA();
    h_v1 = 1; h_v2 = 1;
    step();
    h_v1 = 0; h_v2 = 0;
    expect_beat("mr.b0", 0, 8'h05, 0);
    step(); expect_beat("mr.b1", 0, 8'h70, 0);
    iRST = 1'b0;
    step();
    expect_idle("mr.rst", 0);
    check_eq("mr.data", h_od0, 0);
`ifdef DELTA_SATCNT_EN
    check_eq("mr.satcnt", h_sc, 0);
`endif
    iRST = 1'b1;
    step();
    expect_idle("mr.after", 0);
    load_hB();
    h_v1 = 1; h_v2 = 1;
    step();
    h_v1 = 0; h_v2 = 0;
    expect_beat("mr.B0", 0, 8'h78, 0);
    step(); expect_beat("mr.B1", 0, 8'h80, 0);
    step(); expect_beat("mr.B2", 0, 8'h07, 1);
    step(); expect_idle("mr.end", 0);
`ifdef DELTA_SATCNT_EN
    check_eq("mr.satcnt_B", h_sc, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
